uart_tx_mmio: RTL and testbench

- Memory-mapped UART transmitter on the downstream side of the cpu data bus.
- Consumes the cpu's addr/do/we outputs.
- Buffers written bytes in a small FIFO and serialises them 8N1, LSB first, on a single tx line.
- Returns a registered status byte and a hit flag; the top-level di mux uses these to select this block's read data over memory.

---
 rtl/uart_tx_mmio.sv | 215 +++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter on the cpu data bus.
// TXDATA at BASE_ADDR pushes a byte into a small FIFO; STATUS at BASE_ADDR+1
// reads {3'b0, parity_built, overflow, fifo_empty, fifo_full, busy} and a
// write to it clears overflow. Frames are 8N1, LSB first, on a registered tx.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit before stop.
//
// state  | meaning
// IDLE   | line high, waiting for the FIFO to hold a byte
// START  | start bit (tx low)
// DATA   | eight data bits, LSB first
// PARITY | even parity over the data bits (UART_TX_PARITY_EN only)
// STOP   | stop bit (tx high); next byte may start without a gap
module uart_tx_mmio #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_AW      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        we,
  output logic [7:0]  rdata,
  output logic        sel,
  output logic        tx
);

  localparam logic [15:0]      STATUS_ADDR = BASE_ADDR + 16'd1;
  localparam logic [15:0]      BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] DEPTH       = {1'b1, {FIFO_AW{1'b0}}};

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_BUILT = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  localparam logic PARITY_BUILT = 1'b0;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  state_e             state_q, state_d;
  logic [15:0]        baud_q, baud_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif
  logic [7:0]         mem_q [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               sel_q, sel_d;

  logic       fifo_empty, fifo_full, pop, push, push_req, ovf_set;
  logic [7:0] status;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH);
  assign status     = {3'b000, PARITY_BUILT, ovf_q, fifo_empty, fifo_full, state_q != S_IDLE};

  // Transmit FSM: next state, baud counter, shifter and line level.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          baud_d  = BAUD_RELOAD;
          state_d = S_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^mem_q[rd_ptr_q];
`endif
        end
      end
      S_START: begin
        if (baud_q == 16'd0) begin
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = 3'd0;
          baud_d    = BAUD_RELOAD;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (baud_q == 16'd0) begin
          baud_d = BAUD_RELOAD;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_q == 16'd0) begin
          tx_d    = 1'b1;
          baud_d  = BAUD_RELOAD;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (baud_q == 16'd0) begin
          if (!fifo_empty) begin
            // back-to-back frame: no idle cycle between stop and start
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            baud_d  = BAUD_RELOAD;
            state_d = S_START;
`ifdef UART_TX_PARITY_EN
            parity_d = ^mem_q[rd_ptr_q];
`endif
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping, overflow flag and registered bus read path.
  always_comb begin
    push_req = we && (addr == BASE_ADDR);
    push     = push_req && (!fifo_full || pop);
    ovf_set  = push_req && fifo_full && !pop;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // a simultaneous overflow outranks the clear
    if (ovf_set)                          ovf_d = 1'b1;
    else if (we && (addr == STATUS_ADDR)) ovf_d = 1'b0;
    else                                  ovf_d = ovf_q;
    sel_d   = (addr == BASE_ADDR) || (addr == STATUS_ADDR);
    rdata_d = (addr == STATUS_ADDR) ? status : 8'h00;
  end

  // State register with synchronous reset; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      baud_q    <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      rdata_q   <= 8'h00;
      sel_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      rdata_q   <= rdata_d;
      sel_q     <= sel_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = rdata_q;
  assign sel   = sel_q;
  assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: directed scenarios plus randomized bus traffic,
// checked every cycle against a frame-level reference model.
module tb_uart_tx_mmio;

  localparam int          CPB   = 4;
  localparam int          AW    = 2;
  localparam int          DEPTH = 4;
  localparam logic [15:0] BASE  = 16'hFF00;
  localparam logic [15:0] STAT  = 16'hFF01;
`ifdef UART_TX_PARITY_EN
  localparam int          FRAME_BITS = 11;
  localparam logic [7:0]  PAR_FLAG   = 8'h10;
`else
  localparam int          FRAME_BITS = 10;
  localparam logic [7:0]  PAR_FLAG   = 8'h00;
`endif
  localparam int          FRAME = FRAME_BITS * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  rdata;
  logic        sel;
  logic        tx;

  uart_tx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we),
    .rdata(rdata), .sel(sel), .tx(tx)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: byte queue plus position inside the current frame
  logic [7:0] m_q[$];
  bit         m_active = 1'b0;
  int         m_k = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_ovf = 1'b0;
  logic       sel_e = 1'b0;
  logic [7:0] rdata_e = 8'h00;
  logic       tx_e = 1'b1;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %02h expected %02h", tag, $time, got, exp);
    end
  endtask

  function automatic logic line_bit(input int kk, input logic [7:0] b);
    int slot;
    slot = kk / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (FRAME_BITS == 11 && slot == 9) return ^b;
    return 1'b1;
  endfunction

  // one bus cycle: drive, advance the model across the edge, compare
  task automatic step(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
    logic [7:0] st;
    bit full_pre, popped;
    rst = r; we = w; addr = a; wdata = d;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_active = 1'b0; m_k = 0; m_ovf = 1'b0;
      sel_e = 1'b0; rdata_e = 8'h00; tx_e = 1'b1;
    end else begin
      full_pre = (m_q.size() == DEPTH);
      st = PAR_FLAG | {4'b0000, m_ovf, m_q.size() == 0, full_pre, m_active};
      sel_e   = (a == BASE) || (a == STAT);
      rdata_e = (a == STAT) ? st : 8'h00;
      popped = 1'b0;
      if (m_active) begin
        m_k++;
        if (m_k == FRAME) m_active = 1'b0;
      end
      if (!m_active && m_q.size() != 0) begin
        m_cur = m_q.pop_front();
        m_active = 1'b1; m_k = 0; popped = 1'b1;
      end
      if (w && a == BASE) begin
        if (!full_pre || popped) m_q.push_back(d);
        else m_ovf = 1'b1;
      end else if (w && a == STAT) begin
        m_ovf = 1'b0;
      end
      tx_e = m_active ? line_bit(m_k, m_cur) : 1'b1;
    end
    #1;
    check_val("tx", {7'b0, tx}, {7'b0, tx_e});
    check_val("sel", {7'b0, sel}, {7'b0, sel_e});
    check_val("rdata", rdata, rdata_e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h1234, 8'h00);
  endtask

  initial begin
    int wr_pct;
    logic w, r;
    logic [15:0] a;

    step(1'b1, 1'b0, 16'h0000, 8'h00);
    step(1'b1, 1'b0, 16'h0000, 8'h00);
    idle(20);
    check_val("idle_tx", {7'b0, tx}, 8'h01);
    step(1'b0, 1'b0, STAT, 8'h00);
    check_val("idle_sel", {7'b0, sel}, 8'h01);
    check_val("idle_status", rdata, 8'h04 | PAR_FLAG);

    // single frame
    step(1'b0, 1'b1, BASE, 8'hA5);
    idle(FRAME + 5);

    // three back-to-back frames
    step(1'b0, 1'b1, BASE, 8'h01);
    step(1'b0, 1'b1, BASE, 8'h02);
    step(1'b0, 1'b1, BASE, 8'h03);
    idle(3 * FRAME + 5);
    step(1'b0, 1'b0, STAT, 8'h00);
    check_val("drained_status", rdata, 8'h04 | PAR_FLAG);

    // overflow and clear
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, BASE, 8'h10 + 8'(i));
    step(1'b0, 1'b0, STAT, 8'h00);
    check_val("ovf_status", rdata, 8'h0B | PAR_FLAG);
    step(1'b0, 1'b1, STAT, 8'h00);
    step(1'b0, 1'b0, STAT, 8'h00);
    check_val("ovf_cleared", rdata, 8'h03 | PAR_FLAG);
    idle(5 * FRAME + 5);

    // reset in the middle of a frame
    step(1'b0, 1'b1, BASE, 8'h3C);
    step(1'b0, 1'b1, BASE, 8'hC3);
    idle(14);
    step(1'b1, 1'b0, 16'h0000, 8'h00);
    check_val("rst_tx", {7'b0, tx}, 8'h01);
    step(1'b0, 1'b0, STAT, 8'h00);
    check_val("rst_status", rdata, 8'h04 | PAR_FLAG);
    idle(2 * FRAME);

    // parity-relevant byte
    step(1'b0, 1'b1, BASE, 8'h07);
    idle(FRAME + 5);

    // randomized traffic in blocks of varying write intensity
    for (int blk = 0; blk < 12; blk++) begin
      wr_pct = $urandom_range(0, 50);
      for (int c = 0; c < 250; c++) begin
        w = ($urandom_range(0, 99) < wr_pct);
        case ($urandom_range(0, 3))
          0, 1:    a = BASE;
          2:       a = STAT;
          default: a = 16'($urandom_range(0, 65535));
        endcase
        r = ($urandom_range(0, 799) == 0);
        step(r, w, a, 8'($urandom_range(0, 255)));
      end
    end
    idle(6 * FRAME);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
